sc_fifo_hs: RTL and testbench
=============================

# sc_fifo_hs

Single-clock synchronous FIFO that replaces the basic counter-pointer FIFO. It uses the full 2**AW storage depth via (AW+1)-bit pointers and offers standard or first-word-fall-through (FWFT) read mode. It protects against overflow and underflow, and adds programmable almost-full/almost-empty flags and sticky error flags. It sits between a producer and consumer in the same clock domain and uses an internal simple-dual-port RAM with a 1-cycle registered read.

## Interface
- DW, 8: data width in bits.
- AW, 10: address width; storage depth DEPTH = 2**AW entries.
- FWFT, 0: 0 = standard mode (dout valid 1 cycle after an accepted read); 1 = first-word-fall-through (dout shows the head word whenever empty=0).
- AFULL_TH, 2**AW-2: almost_full asserts when data_cnt >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when data_cnt <= AEMPTY_TH.

- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DW  write data.
- write  in  1  write request.
- full  out  1  no space; writes are rejected.
- almost_full  out  1  data_cnt >= AFULL_TH.
- read  in  1  read/pop request.
- dout  out  DW  read data.
- empty  out  1  no readable word.
- almost_empty  out  1  data_cnt <= AEMPTY_TH.
- data_cnt  out  AW+1  words accepted and not yet popped, range 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- Accepted write: wr_ok = write & ~full. Accepted read: rd_ok = read & ~empty. Both use the registered flag values of the current cycle.
- Rejected requests do not change pointers, count or dout.
- Pointers wr_ptr and rd_ptr are AW+1 bits wide and wrap modulo 2**(AW+1). The RAM address is ptr[AW-1:0].
- data_cnt: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- full = (data_cnt == DEPTH). This uses every entry; there is no wasted slot.
- Full with read and write both asserted: the read is accepted and the write is rejected (overflow set). No same-address read/write collision is ever allowed.
- Empty with read and write both asserted: the write is accepted and the read is rejected (underflow set).
- Standard mode:
  - empty = (data_cnt == 0).
  - rd_ok issues a RAM read; dout is updated on the next edge.
  - dout holds its last value otherwise.
- FWFT mode:
  - An output register (valid bit ov) is fed by a prefetch state machine with states IDLE (ov=0, nothing in flight), FETCH (RAM read in flight), and HOLD (ov=1).
  - empty = ~ov. data_cnt includes the word held in the output register.
  - rd_ok in HOLD with RAM words remaining issues the next RAM read in the same cycle. The next word appears one cycle later, and ov drops for that one cycle (no back-to-back pops in FWFT).
  - rd_ok in HOLD with no RAM words goes to IDLE.
- overflow/underflow: set on a rejected request and cleared by err_clr. If set and clear coincide, set wins.
- almost_full and almost_empty are combinational compares on the registered data_cnt.

## Timing
- Reset values: pointers 0, data_cnt 0, dout 0, empty 1, full 0, almost_empty 1, almost_full 0 (AFULL_TH > 0), overflow 0, underflow 0, FWFT state IDLE.
- Reset takes effect asynchronously. Reset asserted mid-operation discards all contents and any in-flight prefetch; the first accepted write after release behaves as into an empty FIFO.
- A write in cycle N updates data_cnt and full at edge N+1.
- Standard mode: empty deasserts at N+1; a read accepted in cycle M gives dout valid at M+1.
- FWFT mode, write into an empty FIFO at cycle N: RAM write at edge N+1, prefetch read in cycle N+1, dout valid and empty=0 at N+2. data_cnt=1 from N+1.
- Throughput: one write per cycle in both modes; one read per cycle in standard mode.

## Test plan
- AW=4, standard mode: write 0x00..0x0F in consecutive cycles. Required: full=1 after the 16th edge and data_cnt=16. A 17th write sets overflow=1 with data_cnt unchanged. Then read 16 words and check dout 0x00..0x0F in order, ending with empty=1.
- AW=4, wrap-around: 40 cycles of simultaneous write and read at data_cnt=5. Required: data_cnt stays 5 throughout, data stays in order, pointers pass 31→0 cleanly.
- Full+read+write and empty+read+write: full case gives data_cnt 16→15 with overflow=1. Empty case gives data_cnt 0→1 with underflow=1 and dout unchanged.
- FWFT=1: a single write of 0xA5 at cycle N gives empty=0 and dout=0xA5 at N+2. Reading it gives empty=1 next cycle and data_cnt=0.
- Thresholds AFULL_TH=14, AEMPTY_TH=2: almost_empty falls when data_cnt goes 2→3, and almost_full rises when data_cnt goes 13→14.
- rst_n pulsed low mid-fill at data_cnt=7 (FWFT=1, with a prefetch in flight): all outputs return to reset values immediately. A later write of 0x3C appears at dout 2 cycles after it is written.

Source files
------------

// File: rtl/sc_fifo_hs.sv
// Single-clock FIFO using the full 2**AW storage via (AW+1)-bit pointers.
// Standard or FWFT read mode, threshold flags and sticky error flags.
module sc_fifo_hs #(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (2**AW) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          write,
    output logic          full,
    output logic          almost_full,
    input  logic          read,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   data_cnt,
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_C    = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AEMPTY_TH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] dout_q;
    logic [1:0]    st_q, st_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          full_w;
    logic          empty_w;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_rd;
    logic [AW:0]   ram_cnt;

    assign full_w  = (cnt_q == DEPTH_C);
    assign empty_w = (FWFT != 0) ? (st_q != S_HOLD) : (cnt_q == '0);
    assign wr_ok   = write & ~full_w;
    assign rd_ok   = read & ~empty_w;
    // Words still sitting in the RAM (excludes the FWFT output word)
    assign ram_cnt = wr_ptr_q - rd_ptr_q;

    always_comb begin
        st_d   = st_q;
        ram_rd = 1'b0;
        if (FWFT != 0) begin
            case (st_q)
                S_IDLE: begin
                    if (ram_cnt != '0) begin
                        ram_rd = 1'b1;
                        st_d   = S_HOLD;
                    end
                end
                S_FETCH: st_d = S_HOLD;
                S_HOLD: begin
                    if (rd_ok) begin
                        if (ram_cnt != '0) begin
                            ram_rd = 1'b1;
                            st_d   = S_FETCH;
                        end else begin
                            st_d = S_IDLE;
                        end
                    end
                end
                default: st_d = S_IDLE;
            endcase
        end else begin
            ram_rd = rd_ok;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, ram_rd};
    // A new error event takes priority over a simultaneous clear
    assign ovf_d    = (write & full_w) | (ovf_q & ~err_clr);
    assign udf_d    = (read & empty_w) | (udf_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            st_q     <= S_IDLE;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            if (ram_rd) begin
                dout_q <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign data_cnt     = cnt_q;
    assign dout         = dout_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sc_fifo_hs.sv
// Directed bench for sc_fifo_hs: standard-mode and FWFT instances, AW=4.
module tb_sc_fifo_hs;

    logic clk;
    logic rst_n;

    logic [7:0] din_a, dout_a;
    logic       wr_a, rd_a, clr_a;
    logic       full_a, af_a, empty_a, ae_a, ovf_a, udf_a;
    logic [4:0] cnt_a;

    logic [7:0] din_b, dout_b;
    logic       wr_b, rd_b, clr_b;
    logic       full_b, af_b, empty_b, ae_b, ovf_b, udf_b;
    logic [4:0] cnt_b;

    int checks = 0;
    int errors = 0;

    sc_fifo_hs #(
        .DW(8), .AW(4), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .din(din_a), .write(wr_a),
        .full(full_a), .almost_full(af_a), .read(rd_a), .dout(dout_a),
        .empty(empty_a), .almost_empty(ae_a), .data_cnt(cnt_a),
        .overflow(ovf_a), .underflow(udf_a), .err_clr(clr_a)
    );

    sc_fifo_hs #(
        .DW(8), .AW(4), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(din_b), .write(wr_b),
        .full(full_b), .almost_full(af_b), .read(rd_b), .dout(dout_b),
        .empty(empty_b), .almost_empty(ae_b), .data_cnt(cnt_b),
        .overflow(ovf_b), .underflow(udf_b), .err_clr(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = '0; wr_a = 0; rd_a = 0; clr_a = 0;
        din_b = '0; wr_b = 0; rd_b = 0; clr_b = 0;
        #12;
        chk("rst_std_empty", empty_a, 1);
        chk("rst_std_full", full_a, 0);
        chk("rst_std_cnt", cnt_a, 0);
        chk("rst_std_dout", dout_a, 0);
        chk("rst_std_ae", ae_a, 1);
        chk("rst_std_af", af_a, 0);
        chk("rst_std_ovf", ovf_a, 0);
        chk("rst_std_udf", udf_a, 0);
        chk("rst_fwft_empty", empty_b, 1);
        chk("rst_fwft_cnt", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill standard FIFO with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_a = 1; din_a = 8'(i);
            tick();
            chk("fill_cnt", cnt_a, i + 1);
            chk("fill_ae", ae_a, (i + 1 <= 2) ? 1 : 0);
            chk("fill_af", af_a, (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", full_a, (i == 15) ? 1 : 0);
        end
        din_a = 8'h99;
        tick();
        chk("ovf_set", ovf_a, 1);
        chk("ovf_cnt", cnt_a, 16);
        wr_a = 0; clr_a = 1;
        tick();
        clr_a = 0;
        chk("ovf_clr", ovf_a, 0);

        // Full with read and write: read wins, write rejected
        wr_a = 1; rd_a = 1; din_a = 8'h55;
        tick();
        chk("frw_cnt", cnt_a, 15);
        chk("frw_ovf", ovf_a, 1);
        chk("frw_dout", dout_a, 8'h00);
        chk("frw_full", full_a, 0);
        wr_a = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("drain_dout", dout_a, i);
        end
        rd_a = 0;
        chk("drain_empty", empty_a, 1);
        chk("drain_cnt", cnt_a, 0);

        // Empty with read and write: write wins, read rejected
        clr_a = 1;
        tick();
        clr_a = 0;
        wr_a = 1; rd_a = 1; din_a = 8'h77;
        tick();
        chk("erw_cnt", cnt_a, 1);
        chk("erw_udf", udf_a, 1);
        chk("erw_dout", dout_a, 8'h0F);
        chk("erw_empty", empty_a, 0);
        chk("erw_ovf", ovf_a, 0);
        wr_a = 0;
        tick();
        rd_a = 0;
        chk("erw_pop", dout_a, 8'h77);
        chk("erw_empty2", empty_a, 1);

        // Wrap-around at steady occupancy 5
        for (int i = 0; i < 5; i++) begin
            wr_a = 1; din_a = 8'h20 + 8'(i);
            tick();
        end
        chk("wrap_pre_cnt", cnt_a, 5);
        rd_a = 1;
        for (int k = 0; k < 40; k++) begin
            din_a = 8'h25 + 8'(k);
            tick();
            chk("wrap_dout", dout_a, 8'h20 + k);
            chk("wrap_cnt", cnt_a, 5);
        end
        wr_a = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("wrap_tail", dout_a, 8'h48 + j);
        end
        rd_a = 0;
        chk("wrap_empty", empty_a, 1);

        // FWFT: single word latency
        wr_b = 1; din_b = 8'hA5;
        tick();
        wr_b = 0;
        chk("fw_n1_empty", empty_b, 1);
        chk("fw_n1_cnt", cnt_b, 1);
        tick();
        chk("fw_n2_empty", empty_b, 0);
        chk("fw_n2_dout", dout_b, 8'hA5);
        rd_b = 1;
        tick();
        rd_b = 0;
        chk("fw_pop_empty", empty_b, 1);
        chk("fw_pop_cnt", cnt_b, 0);

        // FWFT fill to 7, then pop+push to put a fetch in flight
        for (int i = 0; i < 7; i++) begin
            wr_b = 1; din_b = 8'h10 + 8'(i);
            tick();
        end
        chk("fw_fill_cnt", cnt_b, 7);
        chk("fw_fill_dout", dout_b, 8'h10);
        chk("fw_fill_empty", empty_b, 0);
        din_b = 8'h17; rd_b = 1;
        tick();
        wr_b = 0; rd_b = 0;
        chk("fw_fetch_empty", empty_b, 1);
        chk("fw_fetch_cnt", cnt_b, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt_b, 0);
        chk("mid_rst_empty", empty_b, 1);
        chk("mid_rst_dout", dout_b, 0);
        chk("mid_rst_ae", ae_b, 1);
        chk("mid_rst_std_cnt", cnt_a, 0);
        chk("mid_rst_std_udf", udf_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", empty_b, 1);
        wr_b = 1; din_b = 8'h3C;
        tick();
        wr_b = 0;
        chk("post_n1_empty", empty_b, 1);
        chk("post_n1_cnt", cnt_b, 1);
        tick();
        chk("post_n2_empty", empty_b, 0);
        chk("post_n2_dout", dout_b, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
